// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Control sequencer for a BCD lap counter. It conditions the start
//   pushbutton, runs a prescaler that paces the external count datapath,
//   counts completed laps and drives the status LEDs.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rst            synchronous reset, active low
//   start          raw pushbutton level (asynchronous, high = pressed)
//   set_0, set_1   modulus select: 00->10, 01->24, 10->60, 11->99
//   set_2          rate select: 1 = PERIOD_FAST, 0 = PERIOD_SLOW
//   recount        count direction: 1 = down, 0 = up
//   term_cnt       datapath is at the end value for the current direction
//   tick           one-cycle count enable to the datapath (registered)
//   load           datapath preset load (registered)
//   dir            registered copy of recount
//   preset_shi/ge  BCD preset digits (tens / ones)
//   lap            completed laps, 0..LAPS
//   done           high while in DONE
//   status_led_r/g status LEDs (RUN = red, IDLE/PAUSE = green, DONE = off)
module counter_sequencer #(
    parameter int PERIOD_FAST = 1500000,
    parameter int PERIOD_SLOW = 6000000,
    parameter int DEBOUNCE    = 240000,
    parameter int LAPS        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       set_0,
    input  logic       set_1,
    input  logic       set_2,
    input  logic       recount,
    input  logic       term_cnt,
    output logic       tick,
    output logic       load,
    output logic       dir,
    output logic [3:0] preset_shi,
    output logic [3:0] preset_ge,
    output logic [3:0] lap,
    output logic       done,
    output logic       status_led_r,
    output logic       status_led_g
);

    localparam int          DW       = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
    localparam logic [23:0] FAST_M1  = 24'(PERIOD_FAST - 1);
    localparam logic [23:0] SLOW_M1  = 24'(PERIOD_SLOW - 1);
    localparam logic [3:0]  LAPS_V   = 4'(LAPS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // start conditioning: 2-FF synchronizer, then a debouncer that flips
    // its output only after DEBOUNCE consecutive samples that disagree
    // with it. press_q pulses for one cycle on each debounced rising edge.
    // ------------------------------------------------------------------
    logic          sync_0, sync_1;
    logic          deb_q;
    logic [DW-1:0] deb_cnt;
    logic          press_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_0  <= 1'b0;
            sync_1  <= 1'b0;
            deb_q   <= 1'b0;
            deb_cnt <= '0;
            press_q <= 1'b0;
        end else begin
            sync_0  <= start;
            sync_1  <= sync_0;
            press_q <= 1'b0;
            if (sync_1 == deb_q) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_q   <= sync_1;
                deb_cnt <= '0;
                press_q <= sync_1;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Configuration registers. They load every cycle, reset included, so
    // after reset they already mirror the switches and no change event
    // fires spuriously.
    // ------------------------------------------------------------------
    logic [1:0] sel_q;
    logic       dir_q;
    logic       rate_q;
    logic       cfg_change;

    always_ff @(posedge clk) begin
        sel_q  <= {set_0, set_1};
        dir_q  <= recount;
        rate_q <= set_2;
    end

    assign cfg_change = ({set_0, set_1, recount} != {sel_q, dir_q});
    assign dir        = dir_q;

    // Preset digits follow the registered configuration.
    logic [3:0] mod_tens, mod_ones;

    always_comb begin
        mod_tens = 4'd1;
        mod_ones = 4'd0;
        case (sel_q)
            2'b00:   begin mod_tens = 4'd1; mod_ones = 4'd0; end
            2'b01:   begin mod_tens = 4'd2; mod_ones = 4'd4; end
            2'b10:   begin mod_tens = 4'd6; mod_ones = 4'd0; end
            default: begin mod_tens = 4'd9; mod_ones = 4'd9; end
        endcase
        if (dir_q) begin
            preset_shi = mod_tens;
            preset_ge  = mod_ones;
        end else begin
            preset_shi = 4'd0;
            preset_ge  = 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic [23:0] presc_q, presc_d;
    logic [3:0]  lap_q, lap_d;
    logic [3:0]  lap_inc;
    logic [23:0] period_m1;
    logic        expiry;
    logic        tick_d, load_d;

    assign period_m1 = rate_q ? FAST_M1 : SLOW_M1;
    // >= rather than == so a switch to the shorter period while the
    // prescaler is already past it still expires on the next cycle.
    assign expiry    = (presc_q >= period_m1);
    assign lap_inc   = lap_q + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            lap_q   <= '0;
            tick    <= 1'b0;
            load    <= 1'b1;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            lap_q   <= lap_d;
            tick    <= tick_d;
            load    <= load_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        lap_d   = lap_q;
        tick_d  = 1'b0;
        load_d  = 1'b0;

        case (state_q)
            IDLE: begin
                presc_d = '0;
                lap_d   = '0;
                load_d  = 1'b1;
                if (press_q) begin
                    state_d = RUN;
                    load_d  = 1'b0;
                end
            end
            RUN: begin
                // A press wins over an expiry in the same cycle; the
                // prescaler is left untouched so the period resumes later.
                if (press_q) begin
                    state_d = PAUSE;
                end else if (expiry) begin
                    presc_d = '0;
                    if (term_cnt) begin
                        load_d = 1'b1;
                        lap_d  = lap_inc;
                        if (lap_inc == LAPS_V) begin
                            state_d = DONE;
                        end
                    end else begin
                        tick_d = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 24'd1;
                end
            end
            PAUSE: begin
                if (press_q) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (press_q) begin
                    state_d = IDLE;
                    lap_d   = '0;
                    load_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
                lap_d   = '0;
                load_d  = 1'b1;
            end
        endcase

        // A configuration change abandons any progress.
        if ((state_q != IDLE) && cfg_change) begin
            state_d = IDLE;
            presc_d = '0;
            lap_d   = '0;
            tick_d  = 1'b0;
            load_d  = 1'b1;
        end
    end

    assign lap  = lap_q;
    assign done = (state_q == DONE);

    always_comb begin
        status_led_r = 1'b0;
        status_led_g = 1'b0;
        case (state_q)
            RUN:         begin status_led_r = 1'b1; status_led_g = 1'b0; end
            IDLE, PAUSE: begin status_led_r = 1'b0; status_led_g = 1'b1; end
            default:     begin status_led_r = 1'b0; status_led_g = 1'b0; end
        endcase
    end

endmodule
